// File: rtl/game_round_ctl_if.sv
// Signal bundle between the round sequencer and the game datapath (buttons, timer, checker, score display).
interface game_round_ctl_if;
    logic       access_ok;
    logic       timeout;
    logic       bot_bpress;
    logic       player_bpress;
    logic [1:0] sum_status;
    logic       bot_load;
    logic       player_load;
    logic       timer_reconf;
    logic       timer_enable;
    logic [3:0] score;
    logic [2:0] round;
    logic       game_over;
    logic [2:0] state;

    // Datapath side: drives the requests and observes the sequencer.
    modport master (
        output access_ok, timeout, bot_bpress, player_bpress, sum_status,
        input  bot_load, player_load, timer_reconf, timer_enable,
        input  score, round, game_over, state
    );

    // Sequencer side.
    modport slave (
        input  access_ok, timeout, bot_bpress, player_bpress, sum_status,
        output bot_load, player_load, timer_reconf, timer_enable,
        output score, round, game_over, state
    );
endinterface

// File: rtl/game_round_ctl.sv
// Round sequencer for the number-sum game: arms the timer, collects bot/player numbers,
// scores each round from the sum checker and ends the game on round count or timer expiry.
module game_round_ctl #(
    parameter int unsigned ROUNDS = 4
) (
    input logic             clk,
    input logic             rst_n,
    game_round_ctl_if.slave bus
);
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned ROUND_W   = 3;
    localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        BOT    = 3'd2,
        BLOAD  = 3'd3,
        PLAYER = 3'd4,
        PLOAD  = 3'd5,
        EVAL   = 3'd6,
        DONE   = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 bot_load_q, player_load_q, timer_reconf_q, timer_enable_q, game_over_q;
    logic                 bot_load_d, player_load_d, timer_reconf_d, timer_enable_d, game_over_d;

    // Next state, score and round; abort on lost access outranks timeout, which outranks presses.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        round_d = round_q;
        if (state_q != IDLE && !bus.access_ok) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.access_ok) begin
                        state_d = ARM;
                        score_d = '0;
                        round_d = '0;
                    end
                end
                ARM:   state_d = BOT;
                BOT: begin
                    if (bus.timeout)         state_d = DONE;
                    else if (bus.bot_bpress) state_d = BLOAD;
                end
                BLOAD: state_d = PLAYER;
                PLAYER: begin
                    if (bus.timeout)            state_d = DONE;
                    else if (bus.player_bpress) state_d = PLOAD;
                end
                PLOAD: state_d = EVAL;
                EVAL: begin
                    unique case (bus.sum_status)
                        2'b10: if (score_q != SCORE_W'(SCORE_MAX)) score_d = score_q + SCORE_W'(1);
                        2'b00: score_d = score_q;
                        default: if (score_q != '0) score_d = score_q - SCORE_W'(1);
                    endcase
                    round_d = round_q + ROUND_W'(1);
                    state_d = (round_d == ROUND_W'(ROUNDS)) ? DONE : ARM;
                end
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        bot_load_d     = 1'b0;
        player_load_d  = 1'b0;
        timer_reconf_d = 1'b0;
        timer_enable_d = 1'b0;
        game_over_d    = 1'b0;
        unique case (state_d)
            ARM:    timer_reconf_d = 1'b1;
            BOT:    timer_enable_d = 1'b1;
            BLOAD: begin
                bot_load_d     = 1'b1;
                timer_enable_d = 1'b1;
            end
            PLAYER: timer_enable_d = 1'b1;
            PLOAD: begin
                player_load_d  = 1'b1;
                timer_enable_d = 1'b1;
            end
            DONE:   game_over_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            score_q        <= '0;
            round_q        <= '0;
            bot_load_q     <= 1'b0;
            player_load_q  <= 1'b0;
            timer_reconf_q <= 1'b0;
            timer_enable_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            round_q        <= round_d;
            bot_load_q     <= bot_load_d;
            player_load_q  <= player_load_d;
            timer_reconf_q <= timer_reconf_d;
            timer_enable_q <= timer_enable_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.state        = 3'(state_q);
    assign bus.score        = score_q;
    assign bus.round        = round_q;
    assign bus.bot_load     = bot_load_q;
    assign bus.player_load  = player_load_q;
    assign bus.timer_reconf = timer_reconf_q;
    assign bus.timer_enable = timer_enable_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_game_round_ctl.sv
// Directed self-checking bench for game_round_ctl with ROUNDS=4.
module tb_game_round_ctl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    game_round_ctl_if bus ();

    game_round_ctl #(.ROUNDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {bot_load, player_load, timer_reconf, timer_enable, game_over}
    function automatic logic [4:0] outs();
        return {bus.bot_load, bus.player_load, bus.timer_reconf, bus.timer_enable, bus.game_over};
    endfunction

    task automatic test_reset();
        bus.access_ok = 1'b0; bus.timeout = 1'b0; bus.bot_bpress = 1'b0;
        bus.player_bpress = 1'b0; bus.sum_status = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.state !== 3'd0 || bus.score !== 4'd0 || bus.round !== 3'd0 || outs() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d score=%0d round=%0d outs=%b, need 0 0 0 00000",
                     bus.state, bus.score, bus.round, outs());
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_arm();
        bus.access_ok = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || outs() !== 5'b00100) begin
            n_fail++;
            $display("FAIL arm: state=%0d outs=%b, need 1 00100", bus.state, outs());
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd2 || outs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL arm_to_bot: state=%0d outs=%b, need 2 00010", bus.state, outs());
        end
    endtask

    // Plays one round from BOT with immediate presses; ends in BOT of the next round or DONE.
    task automatic play_round(input logic [1:0] status, input int exp_score, input int exp_round);
        bus.bot_bpress = 1'b1;
        tick();
        bus.bot_bpress = 1'b0;
        n_tests++;
        if (bus.state !== 3'd3 || outs() !== 5'b10010) begin
            n_fail++;
            $display("FAIL bload r%0d: state=%0d outs=%b, need 3 10010", exp_round, bus.state, outs());
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.bot_load !== 1'b0) begin
            n_fail++;
            $display("FAIL player r%0d: state=%0d bot_load=%b, need 4 0", exp_round, bus.state, bus.bot_load);
        end
        bus.player_bpress = 1'b1;
        tick();
        bus.player_bpress = 1'b0;
        n_tests++;
        if (bus.state !== 3'd5 || outs() !== 5'b01010) begin
            n_fail++;
            $display("FAIL pload r%0d: state=%0d outs=%b, need 5 01010", exp_round, bus.state, outs());
        end
        bus.sum_status = status;
        tick();
        n_tests++;
        if (bus.state !== 3'd6 || outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL eval r%0d: state=%0d outs=%b, need 6 00000", exp_round, bus.state, outs());
        end
        tick();
        bus.sum_status = 2'b00;
        n_tests++;
        if (bus.score !== 4'(exp_score) || bus.round !== 3'(exp_round) ||
            bus.state !== ((exp_round == 4) ? 3'd7 : 3'd1)) begin
            n_fail++;
            $display("FAIL score r%0d: score=%0d round=%0d state=%0d, need %0d %0d %0d", exp_round,
                     bus.score, bus.round, bus.state, exp_score, exp_round, (exp_round == 4) ? 7 : 1);
        end
        if (exp_round != 4) tick();
    endtask

    task automatic new_game();
        bus.access_ok = 1'b0;
        tick();
        bus.access_ok = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_full_game();
        play_round(2'b10, 1, 1);
        play_round(2'b10, 2, 2);
        play_round(2'b10, 3, 3);
        play_round(2'b10, 4, 4);
        n_tests++;
        if (bus.game_over !== 1'b1 || bus.timer_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL game_over: game_over=%b timer_enable=%b, need 1 0", bus.game_over, bus.timer_enable);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd7 || bus.score !== 4'd4 || bus.round !== 3'd4) begin
            n_fail++;
            $display("FAIL done_hold: state=%0d score=%0d round=%0d, need 7 4 4", bus.state, bus.score, bus.round);
        end
    endtask

    task automatic test_score_sat();
        bus.access_ok = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.score !== 4'd4 || bus.round !== 3'd4) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d score=%0d round=%0d, need 0 4 4", bus.state, bus.score, bus.round);
        end
        bus.access_ok = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || bus.score !== 4'd0 || bus.round !== 3'd0) begin
            n_fail++;
            $display("FAIL clear: state=%0d score=%0d round=%0d, need 1 0 0", bus.state, bus.score, bus.round);
        end
        tick();
        play_round(2'b01, 0, 1);
        play_round(2'b10, 1, 2);
        play_round(2'b11, 0, 3);
        play_round(2'b00, 0, 4);
    endtask

    task automatic test_timeout_race();
        new_game();
        bus.timeout = 1'b1;
        bus.bot_bpress = 1'b1;
        tick();
        bus.timeout = 1'b0;
        bus.bot_bpress = 1'b0;
        n_tests++;
        if (bus.state !== 3'd7 || bus.bot_load !== 1'b0 || bus.round !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_race: state=%0d bot_load=%b round=%0d, need 7 0 0",
                     bus.state, bus.bot_load, bus.round);
        end
    endtask

    task automatic test_abort();
        new_game();
        play_round(2'b10, 1, 1);
        play_round(2'b10, 2, 2);
        bus.bot_bpress = 1'b1;
        tick();
        bus.bot_bpress = 1'b0;
        tick();
        bus.access_ok = 1'b0;
        bus.player_bpress = 1'b1;
        tick();
        bus.player_bpress = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || outs() !== 5'b0 || bus.score !== 4'd2 || bus.round !== 3'd2) begin
            n_fail++;
            $display("FAIL abort: state=%0d outs=%b score=%0d round=%0d, need 0 00000 2 2",
                     bus.state, outs(), bus.score, bus.round);
        end
        bus.access_ok = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || bus.score !== 4'd0 || bus.round !== 3'd0 || bus.timer_reconf !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm: state=%0d score=%0d round=%0d reconf=%b, need 1 0 0 1",
                     bus.state, bus.score, bus.round, bus.timer_reconf);
        end
    endtask

    task automatic test_drop_and_late_timeout();
        tick();
        bus.bot_bpress = 1'b1;
        tick();
        bus.bot_bpress = 1'b0;
        bus.player_bpress = 1'b1;
        tick();
        bus.player_bpress = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.player_load !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_press: state=%0d player_load=%b, need 4 0", bus.state, bus.player_load);
        end
        bus.player_bpress = 1'b1;
        tick();
        bus.player_bpress = 1'b0;
        bus.timeout = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd6) begin
            n_fail++;
            $display("FAIL pload_timeout: state=%0d, need 6", bus.state);
        end
        tick();
        tick();
        tick();
        bus.timeout = 1'b0;
        n_tests++;
        if (bus.state !== 3'd7 || bus.round !== 3'd1 || bus.game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL late_timeout: state=%0d round=%0d game_over=%b, need 7 1 1",
                     bus.state, bus.round, bus.game_over);
        end
    endtask

    task automatic test_reset_mid();
        new_game();
        bus.bot_bpress = 1'b1;
        tick();
        bus.bot_bpress = 1'b0;
        tick();
        bus.player_bpress = 1'b1;
        tick();
        bus.player_bpress = 1'b0;
        n_tests++;
        if (bus.player_load !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: player_load=%b, need 1", bus.player_load);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.state !== 3'd0 || outs() !== 5'b0 || bus.score !== 4'd0 || bus.round !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d outs=%b score=%0d round=%0d, need 0 00000 0 0",
                     bus.state, outs(), bus.score, bus.round);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_full_game();
        test_score_sat();
        test_timeout_race();
        test_abort();
        test_drop_and_late_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/game_round_ctl.md
# game_round_ctl

Round sequencer for the number-sum game. After the access controller grants play, it arms the digit timer, then collects one bot number and one player number per round. It scores each round from the sum checker and ends the game after ROUNDS rounds or on timer expiry. It drives the existing bot/player capture strobes and timer controls, replacing their direct hookup to the access controller.

## Interface
- ROUNDS, 4, rounds per game; legal 1..7
- CLOCK  in  1  system clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low; forces the reset state immediately
- access_ok  in  1  level; high while access is granted (green pass indicator)
- timeout  in  1  level; high while the round timer reads 00
- bot_bpress  in  1  one-cycle pulse from button shaper, bot select
- player_bpress  in  1  one-cycle pulse from button shaper, player entry
- sum_status  in  2  checker result: 2'b10 win, 2'b01 lose, 2'b00 neutral, 2'b11 treated as lose
- bot_load  out  1  one-cycle strobe to the random generator to capture its number
- player_load  out  1  one-cycle strobe to the player load register
- timer_reconf  out  1  one-cycle strobe reloading the timer from its preset
- timer_enable  out  1  level; timer counts while high
- score  out  4  game score, saturating 0..15
- round  out  3  completed rounds this game
- game_over  out  1  level; high in DONE
- state  out  3  current state encoding, for debug display

## Operation
- States and encoding: IDLE 0, ARM 1, BOT 2, BLOAD 3, PLAYER 4, PLOAD 5, EVAL 6, DONE 7.
- All outputs are Moore, decoded from registered state, score and round. There are no combinational input-to-output paths.
- IDLE:
  - With access_ok=1, go to ARM and clear score and round to 0 on that edge.
  - Otherwise stay in IDLE; score and round hold their last values.
- ARM: timer_reconf=1. Go to BOT unconditionally.
- BOT: timer_enable=1.
  - timeout=1 → DONE.
  - Else bot_bpress=1 → BLOAD.
  - player_bpress is ignored.
- BLOAD: bot_load=1, timer_enable=1. Go to PLAYER unconditionally.
- PLAYER: timer_enable=1.
  - timeout=1 → DONE.
  - Else player_bpress=1 → PLOAD.
  - bot_bpress is ignored.
- PLOAD: player_load=1, timer_enable=1. Go to EVAL unconditionally.
- EVAL: sample sum_status.
  - win: score+1, saturating at 15.
  - lose: score-1, saturating at 0.
  - neutral: score unchanged.
  - round increments by 1.
  - If the incremented round equals ROUNDS → DONE; else → ARM.
- DONE: game_over=1; timer_enable=0. Stay in DONE while access_ok=1; score and round hold.
- Abort: access_ok=0 in any state other than IDLE → IDLE on the next edge. No strobe is issued in that cycle; score and round hold.
- Priority in every state: access_ok=0 abort, then timeout, then button pulse.

## Timing
- Reset values: state IDLE; score 0; round 0; all strobes, timer_enable and game_over 0.
- Input to output latency:
  - A button pulse sampled at edge n puts BLOAD or PLOAD in cycle n+1. The matching strobe is high exactly that one cycle.
  - access_ok rising at edge n puts ARM in cycle n+1; timer_reconf is high for exactly one cycle.
  - BOT is entered at n+2, so the timer is reloaded before counting starts.
- EVAL sampling: the player register captures at the end of PLOAD, and sum_status settles combinationally. EVAL therefore samples the current round's sum, one cycle after player_load.
- Per-round minimum: ARM, BOT, BLOAD, PLAYER, PLOAD, EVAL = 6 cycles with immediate presses.
- Press during a strobe state: a second pulse arriving in BLOAD, PLOAD, EVAL or ARM is dropped. It is not queued.
- Timeout and press sampled in the same cycle: timeout wins. No strobe is issued, and the round is not counted.
- Timeout while in BLOAD or PLOAD is not checked. It is acted on in the following BOT or PLAYER state.
- Saturation boundaries: score stays 15 on win and 0 on lose. round never exceeds ROUNDS.
- Reset asserted mid-round clears everything immediately, independent of CLOCK.

## Test plan
- Reset with ROUNDS=4 → state 0, score 0, round 0, all strobes 0. Raise access_ok → timer_reconf high for 1 cycle in ARM, then state 2 with timer_enable=1.
- Four rounds, each with a bot press then a player press, sum_status=2'b10 → bot_load/player_load one cycle each, one cycle after their press. score ends at 4, round at 4, state 7, game_over=1, timer_enable=0.
- Lose at score 0 (sum_status=2'b01) → score stays 0. Sequence win, lose, 2'b11, neutral → score 1, 0, 0, 0.
- In BOT, assert timeout and bot_bpress in the same cycle → next state DONE, no bot_load, round unchanged.
- Drop access_ok while in PLAYER at round 2 → IDLE next cycle, no player_load, score and round held. Re-raise access_ok → score and round clear to 0 and ARM is entered.
- Pulse RESET low mid-PLOAD → player_load and all outputs drop immediately; state 0 with no clock edge.
